// File: rtl/vend_fsm_param.sv
// ---------------------------------------------------------------------------
// vend_fsm_param
//
// Parametrised vending-machine controller. It accumulates coin credit up to
// MAX_CREDIT and serves one of NUM_PROD products, each with its own price
// from the packed PRICES table. A vend deducts the price and pays any
// remainder as change on the following cycle. A cancel refunds the whole
// credit. Every output is a register, so no input reaches an output within
// the same cycle.
//
// Ports:
//   clock, reset     rising-edge clock; synchronous active-high reset
//   coin_valid       a coin is presented this cycle
//   coin_value       value of the presented coin
//   select_valid     a product selection is made this cycle
//   select_id        index of the selected product
//   cancel           refund request
//   credit           current credit
//   vend_valid       one-cycle dispense strobe
//   vend_id          product being dispensed (meaningful with vend_valid)
//   change_valid     one-cycle change strobe
//   change_amount    change to pay while change_valid is high, else 0
//   coin_reject      previous cycle's coin was not accepted
//   short_err        previous cycle's selection lacked credit
//   sel_err          previous cycle's selection index was out of range
//   busy             high while dispensing or paying change
// ---------------------------------------------------------------------------
module vend_fsm_param #(
    parameter int                          NUM_PROD   = 4,
    parameter int                          CREDIT_W   = 8,
    parameter int                          SEL_W      = 2,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES    = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int                          MAX_CREDIT = 50
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                select_valid,
    input  logic [SEL_W-1:0]    select_id,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_valid,
    output logic [SEL_W-1:0]    vend_id,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                coin_reject,
    output logic                short_err,
    output logic                sel_err,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } state_t;

    localparam int                NUM_SLOTS  = 2 ** SEL_W;
    localparam logic [SEL_W:0]    NUM_PROD_W = (SEL_W + 1)'(NUM_PROD);
    localparam logic [CREDIT_W:0] MAX_W      = (CREDIT_W + 1)'(MAX_CREDIT);

    state_t state, state_next;
    logic [CREDIT_W-1:0] credit_next;

    // Next values of the registered outputs.
    logic                vend_valid_n;
    logic [SEL_W-1:0]    vend_id_n;
    logic                change_valid_n;
    logic [CREDIT_W-1:0] change_amount_n;
    logic                coin_reject_n;
    logic                short_err_n;
    logic                sel_err_n;
    logic                busy_n;

    // Price lookup padded to the full select range; unused slots read 0 but
    // are never used because the index check blocks them.
    logic [CREDIT_W-1:0] price_tab [NUM_SLOTS];

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_price
        if (i < NUM_PROD) begin : g_used
            assign price_tab[i] = PRICES[i*CREDIT_W +: CREDIT_W];
        end else begin : g_unused
            assign price_tab[i] = '0;
        end
    end

    // Shared decision terms. A selection is judged against the credit held
    // before this cycle's coin, so only credit (the register) feeds them.
    logic                accepting;
    logic                sel_idx_ok;
    logic [CREDIT_W-1:0] price_sel;
    logic                credit_ok;
    logic                do_cancel;
    logic                do_vend;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] remain;

    assign accepting  = (state == S_IDLE) || (state == S_CREDIT);
    assign sel_idx_ok = {1'b0, select_id} < NUM_PROD_W;
    assign price_sel  = price_tab[select_id];
    assign credit_ok  = credit >= price_sel;
    assign do_cancel  = accepting && cancel;
    assign do_vend    = accepting && !cancel && select_valid && sel_idx_ok && credit_ok;
    // One extra bit so the ceiling test cannot be fooled by wrap-around.
    assign coin_sum   = {1'b0, credit} + {1'b0, coin_value};
    // A pending cancel or a successful vend takes the cycle; the coin loses.
    assign coin_ok    = accepting && !cancel && !do_vend && coin_valid &&
                        (coin_value != '0) && (coin_sum <= MAX_W);
    assign remain     = credit - price_sel;

    // State register and output registers.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so the order of these lines does not matter.
        if (reset) begin
            state         <= S_IDLE;
            credit        <= '0;
            vend_valid    <= 1'b0;
            vend_id       <= '0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            coin_reject   <= 1'b0;
            short_err     <= 1'b0;
            sel_err       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            credit        <= credit_next;
            vend_valid    <= vend_valid_n;
            vend_id       <= vend_id_n;
            change_valid  <= change_valid_n;
            change_amount <= change_amount_n;
            coin_reject   <= coin_reject_n;
            short_err     <= short_err_n;
            sel_err       <= sel_err_n;
            busy          <= busy_n;
        end
    end

    // Next-state and credit logic.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no
        // latch is inferred.
        state_next  = state;
        credit_next = credit;
        case (state)
            S_IDLE, S_CREDIT: begin
                if (do_cancel) begin
                    // Cancel with no credit (IDLE) does nothing.
                    if (state == S_CREDIT) state_next = S_CHANGE;
                end else if (do_vend) begin
                    state_next  = S_VEND;
                    credit_next = remain;
                end else if (coin_ok) begin
                    state_next  = S_CREDIT;
                    credit_next = coin_sum[CREDIT_W-1:0];
                end
            end
            S_VEND: begin
                state_next = (credit != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                state_next  = S_IDLE;
                credit_next = '0;
            end
            default: begin
                state_next  = S_IDLE;
                credit_next = '0;
            end
        endcase
    end

    // Output logic: values the output registers take at the next edge.
    always_comb begin
        vend_valid_n    = do_vend;
        vend_id_n       = do_vend ? select_id : vend_id;
        change_valid_n  = (do_cancel && (state == S_CREDIT)) ||
                          ((state == S_VEND) && (credit != '0));
        // Entering CHANGE the credit register still holds the amount owed.
        change_amount_n = change_valid_n ? credit : '0;
        coin_reject_n   = coin_valid && !coin_ok;
        short_err_n     = accepting && !cancel && select_valid && sel_idx_ok && !credit_ok;
        sel_err_n       = accepting && !cancel && select_valid && !sel_idx_ok;
        busy_n          = (state_next == S_VEND) || (state_next == S_CHANGE);
    end

endmodule
